// File: rtl/galvo_scan_spi.sv
// Galvo raster positioning engine: steps H/V on each go and writes both codes
// to a dual-channel DAC over SPI mode 0, then pulses galvo_spi_done.
module galvo_scan_spi #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic        clk_adc,
  input  logic        rst_adc_n,
  input  logic        go,
  input  logic [10:0] h_start,
  input  logic [10:0] h_end,
  input  logic [10:0] h_step,
  input  logic [10:0] v_start,
  input  logic [10:0] v_end,
  input  logic [10:0] v_step,
  output logic [10:0] galvoh,
  output logic [10:0] galvov,
  output logic        galvo_spi_done,
  output logic        frame_done,
  output logic        busy,
  output logic        overrun,
  input  logic        overrun_clr,
  output logic        spi_sclk,
  output logic        spi_csn,
  output logic        spi_mosi
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CALC    = 3'd1;
  localparam logic [2:0] SHIFT_H = 3'd2;
  localparam logic [2:0] GAP     = 3'd3;
  localparam logic [2:0] SHIFT_V = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [3:0] GAP_LAST = 4'(CS_GAP - 1);

  logic [2:0]  state_reg;
  logic        first_reg;
  logic [10:0] h_start_reg, h_end_reg, h_step_reg;
  logic [10:0] v_start_reg, v_end_reg, v_step_reg;
  logic [10:0] nh_reg, nv_reg;
  logic        frame_flag_reg;
  logic [23:0] shift_reg;
  logic [3:0]  div_cnt_reg;
  logic [4:0]  bit_cnt_reg;
  logic [3:0]  gap_cnt_reg;
  logic        sclk_reg, csn_reg, done_reg, frame_done_reg, busy_reg, overrun_reg;
  logic [10:0] galvoh_reg, galvov_reg;

  logic [11:0] h_sum, v_sum;
  logic        h_wrap, v_wrap;
  logic [10:0] calc_h, calc_v;
  logic        calc_frame;

  function automatic logic [23:0] dac_word(input logic [3:0] addr, input logic [10:0] code);
    return {4'b0011, addr, code, 5'b00000};
  endfunction

  // 12-bit sums so a step past 2047 is seen as a wrap instead of aliasing low
  always_comb begin
    h_sum      = {1'b0, galvoh_reg} + {1'b0, h_step_reg};
    v_sum      = {1'b0, galvov_reg} + {1'b0, v_step_reg};
    h_wrap     = (h_step_reg == 11'd0) || (h_sum > {1'b0, h_end_reg});
    v_wrap     = (v_step_reg == 11'd0) || (v_sum > {1'b0, v_end_reg});
    calc_h     = h_sum[10:0];
    calc_v     = galvov_reg;
    calc_frame = 1'b0;
    if (first_reg) begin
      calc_h = h_start_reg;
      calc_v = v_start_reg;
    end else if (h_wrap) begin
      calc_h = h_start_reg;
      if (v_wrap) begin
        calc_v     = v_start_reg;
        calc_frame = 1'b1;
      end else begin
        calc_v = v_sum[10:0];
      end
    end
  end

  always_ff @(posedge clk_adc or negedge rst_adc_n) begin
    if (!rst_adc_n) begin
      state_reg      <= IDLE;
      first_reg      <= 1'b1;
      h_start_reg    <= '0;
      h_end_reg      <= '0;
      h_step_reg     <= '0;
      v_start_reg    <= '0;
      v_end_reg      <= '0;
      v_step_reg     <= '0;
      nh_reg         <= '0;
      nv_reg         <= '0;
      frame_flag_reg <= 1'b0;
      shift_reg      <= '0;
      div_cnt_reg    <= '0;
      bit_cnt_reg    <= '0;
      gap_cnt_reg    <= '0;
      sclk_reg       <= 1'b0;
      csn_reg        <= 1'b1;
      done_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      busy_reg       <= 1'b0;
      overrun_reg    <= 1'b0;
      galvoh_reg     <= '0;
      galvov_reg     <= '0;
    end else begin
      done_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      // a go outside IDLE (including the DONE cycle) is dropped; set beats clear
      if (go && state_reg != IDLE) overrun_reg <= 1'b1;
      else if (overrun_clr)        overrun_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (go) begin
            h_start_reg <= h_start;
            h_end_reg   <= h_end;
            h_step_reg  <= h_step;
            v_start_reg <= v_start;
            v_end_reg   <= v_end;
            v_step_reg  <= v_step;
            busy_reg    <= 1'b1;
            state_reg   <= CALC;
          end
        end
        CALC: begin
          nh_reg         <= calc_h;
          nv_reg         <= calc_v;
          frame_flag_reg <= calc_frame;
          first_reg      <= 1'b0;
          shift_reg      <= dac_word(4'd0, calc_h);
          csn_reg        <= 1'b0;
          sclk_reg       <= 1'b0;
          div_cnt_reg    <= '0;
          bit_cnt_reg    <= '0;
          state_reg      <= SHIFT_H;
        end
        SHIFT_H, SHIFT_V: begin
          if (div_cnt_reg == DIV_LAST) begin
            div_cnt_reg <= '0;
            if (!sclk_reg) begin
              sclk_reg <= 1'b1;
            end else if (bit_cnt_reg == 5'd23) begin
              sclk_reg  <= 1'b0;
              csn_reg   <= 1'b1;
              shift_reg <= '0;
              if (state_reg == SHIFT_H) begin
                gap_cnt_reg <= '0;
                state_reg   <= GAP;
              end else begin
                done_reg       <= 1'b1;
                frame_done_reg <= frame_flag_reg;
                galvoh_reg     <= nh_reg;
                galvov_reg     <= nv_reg;
                state_reg      <= DONE;
              end
            end else begin
              sclk_reg    <= 1'b0;
              bit_cnt_reg <= bit_cnt_reg + 5'd1;
              shift_reg   <= {shift_reg[22:0], 1'b0};
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + 4'd1;
          end
        end
        GAP: begin
          if (gap_cnt_reg == GAP_LAST) begin
            shift_reg   <= dac_word(4'd1, nv_reg);
            csn_reg     <= 1'b0;
            div_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            state_reg   <= SHIFT_V;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 4'd1;
          end
        end
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign galvoh         = galvoh_reg;
  assign galvov         = galvov_reg;
  assign galvo_spi_done = done_reg;
  assign frame_done     = frame_done_reg;
  assign busy           = busy_reg;
  assign overrun        = overrun_reg;
  assign spi_sclk       = sclk_reg;
  assign spi_csn        = csn_reg;
  assign spi_mosi       = shift_reg[23];

endmodule

// File: tb/tb_galvo_scan_spi.sv
// Scoreboard bench for galvo_scan_spi: default instance plus a CLK_DIV=2/CS_GAP=1
// instance; stimulus queues expected words and done results, monitors pop them.
module tb_galvo_scan_spi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        go_w [2];
  logic [10:0] h_start, h_end, h_step, v_start, v_end, v_step;
  logic        clr;
  logic [10:0] gh [2];
  logic [10:0] gv [2];
  logic        done_w [2];
  logic        fd_w [2];
  logic        busy_w [2];
  logic        ovr_w [2];
  logic        sclk_w [2];
  logic        csn_w [2];
  logic        mosi_w [2];

  always #5 clk = ~clk;

  galvo_scan_spi u_a (
    .clk_adc(clk), .rst_adc_n(rst_n), .go(go_w[0]),
    .h_start(h_start), .h_end(h_end), .h_step(h_step),
    .v_start(v_start), .v_end(v_end), .v_step(v_step),
    .galvoh(gh[0]), .galvov(gv[0]), .galvo_spi_done(done_w[0]), .frame_done(fd_w[0]),
    .busy(busy_w[0]), .overrun(ovr_w[0]), .overrun_clr(clr),
    .spi_sclk(sclk_w[0]), .spi_csn(csn_w[0]), .spi_mosi(mosi_w[0])
  );

  galvo_scan_spi #(.CLK_DIV(2), .CS_GAP(1)) u_b (
    .clk_adc(clk), .rst_adc_n(rst_n), .go(go_w[1]),
    .h_start(h_start), .h_end(h_end), .h_step(h_step),
    .v_start(v_start), .v_end(v_end), .v_step(v_step),
    .galvoh(gh[1]), .galvov(gv[1]), .galvo_spi_done(done_w[1]), .frame_done(fd_w[1]),
    .busy(busy_w[1]), .overrun(ovr_w[1]), .overrun_clr(clr),
    .spi_sclk(sclk_w[1]), .spi_csn(csn_w[1]), .spi_mosi(mosi_w[1])
  );

  typedef struct {
    logic [10:0] h;
    logic [10:0] v;
    logic        fd;
    int          lat;
  } done_t;

  done_t       exp_done_q [$];
  logic [23:0] exp_word_q [$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int go_cyc [2];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [23:0] dac_word(input logic [3:0] addr, input logic [10:0] code);
    return {4'b0011, addr, code, 5'b00000};
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_mon
    localparam int D = (gi == 0) ? 4 : 2;
    localparam int G = (gi == 0) ? 4 : 1;
    initial begin
      logic p_sclk, p_csn, p_mosi, spacing_ok, stable_ok;
      logic [23:0] sh;
      int nbits, low_cnt, last_rise, gap_cnt, word_idx;
      done_t e;
      logic [23:0] ew;
      p_sclk = 0; p_csn = 1; p_mosi = 0; spacing_ok = 1; stable_ok = 1;
      sh = 0; nbits = 0; low_cnt = 0; last_rise = -1; gap_cnt = 0; word_idx = 0;
      forever begin
        @(negedge clk);
        if (rst_n !== 1'b1) begin
          p_sclk = 0; p_csn = 1; p_mosi = 0; nbits = 0; low_cnt = 0;
          gap_cnt = 0; word_idx = 0; last_rise = -1;
        end else begin
          if (done_w[gi]) begin
            if (exp_done_q.size() == 0) flag_fail($sformatf("unexpected_done[%0d]", gi));
            else begin
              e = exp_done_q.pop_front();
              chk($sformatf("galvoh[%0d]", gi), gh[gi], e.h);
              chk($sformatf("galvov[%0d]", gi), gv[gi], e.v);
              chk($sformatf("frame_done[%0d]", gi), fd_w[gi], e.fd);
              chk($sformatf("latency[%0d]", gi), cyc - go_cyc[gi], e.lat);
              chk($sformatf("busy_at_done[%0d]", gi), busy_w[gi], 1'b1);
              $display("inst %0d done: h=%0d v=%0d fd=%0b lat=%0d", gi, gh[gi], gv[gi],
                       fd_w[gi], cyc - go_cyc[gi]);
            end
          end else if (fd_w[gi]) begin
            flag_fail($sformatf("frame_done_without_done[%0d]", gi));
          end
          if (!csn_w[gi]) begin
            if (p_csn) begin
              if (word_idx == 1) chk($sformatf("cs_gap[%0d]", gi), gap_cnt, G);
              nbits = 0; low_cnt = 0; spacing_ok = 1; stable_ok = 1; last_rise = -1; sh = 0;
            end
            low_cnt++;
            if (!p_sclk && sclk_w[gi]) begin
              sh = {sh[22:0], mosi_w[gi]};
              if (last_rise >= 0 && cyc - last_rise != 2 * D) spacing_ok = 0;
              last_rise = cyc;
              nbits++;
            end
            if (p_sclk && sclk_w[gi] && mosi_w[gi] !== p_mosi) stable_ok = 0;
          end else begin
            if (!p_csn) begin
              if (exp_word_q.size() == 0) flag_fail($sformatf("unexpected_word[%0d]", gi));
              else begin
                ew = exp_word_q.pop_front();
                chk($sformatf("spi_word[%0d]", gi), sh, ew);
                $display("inst %0d word: 0x%06h (exp 0x%06h)", gi, sh, ew);
              end
              chk($sformatf("bit_count[%0d]", gi), nbits, 24);
              chk($sformatf("csn_low_cycles[%0d]", gi), low_cnt, 48 * D);
              chk($sformatf("sclk_period_ok[%0d]", gi), spacing_ok, 1'b1);
              chk($sformatf("mosi_stable_high[%0d]", gi), stable_ok, 1'b1);
              word_idx = (word_idx == 0) ? 1 : 0;
              gap_cnt = 0;
            end
            gap_cnt++;
          end
          p_sclk = sclk_w[gi];
          p_csn  = csn_w[gi];
          p_mosi = mosi_w[gi];
        end
      end
    end
  end

  task automatic issue(input int inst, input logic [10:0] eh, input logic [10:0] ev,
                       input logic efd, input int lat);
    done_t e;
    e.h = eh; e.v = ev; e.fd = efd; e.lat = lat;
    exp_word_q.push_back(dac_word(4'd0, eh));
    exp_word_q.push_back(dac_word(4'd1, ev));
    exp_done_q.push_back(e);
    @(negedge clk); #1;
    go_w[inst] = 1'b1;
    go_cyc[inst] = cyc;
    @(negedge clk); #1;
    go_w[inst] = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (exp_done_q.size() != 0 && t < 1500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1500) begin
      flag_fail("done_timeout");
      exp_done_q.delete();
      exp_word_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic set_cfg(input logic [10:0] hs, he, hp, vs, ve, vp);
    h_start = hs; h_end = he; h_step = hp;
    v_start = vs; v_end = ve; v_step = vp;
  endtask

  initial begin
    #1_000_000;
    flag_fail("watchdog");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    rst_n = 1'b0; go_w[0] = 1'b0; go_w[1] = 1'b0; clr = 1'b0;
    set_cfg(11'd0, 11'd2, 11'd1, 11'd0, 11'd1, 11'd1);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_galvoh", gh[0], 11'd0);
    chk("rst_galvov", gv[0], 11'd0);
    chk("rst_done", done_w[0], 1'b0);
    chk("rst_frame_done", fd_w[0], 1'b0);
    chk("rst_busy", busy_w[0], 1'b0);
    chk("rst_overrun", ovr_w[0], 1'b0);
    chk("rst_sclk", sclk_w[0], 1'b0);
    chk("rst_csn", csn_w[0], 1'b1);
    chk("rst_mosi", mosi_w[0], 1'b0);
    chk("rst_csn_b", csn_w[1], 1'b1);
    #1 rst_n = 1'b1;

    chk("word_format_h", dac_word(4'd0, 11'd0), 24'h300000);
    chk("word_format_v", dac_word(4'd1, 11'd0), 24'h310000);

    // first step lands on (h_start, v_start) with no frame_done
    issue(0, 11'd0, 11'd0, 1'b0, 390);
    wait_done();
    issue(0, 11'd1, 11'd0, 1'b0, 390); wait_done();
    issue(0, 11'd2, 11'd0, 1'b0, 390); wait_done();
    issue(0, 11'd0, 11'd1, 1'b0, 390);
    set_cfg(11'd9, 11'd9, 11'd2, 11'd5, 11'd5, 11'd0);  // mid-transfer change must be ignored
    wait_done();
    set_cfg(11'd0, 11'd2, 11'd1, 11'd0, 11'd1, 11'd1);
    issue(0, 11'd1, 11'd1, 1'b0, 390); wait_done();
    issue(0, 11'd2, 11'd1, 1'b0, 390); wait_done();
    issue(0, 11'd0, 11'd0, 1'b1, 390); wait_done();

    // overrun: go while busy, then clr+go together while busy
    issue(0, 11'd1, 11'd0, 1'b0, 390);
    repeat (48) @(negedge clk);
    #1 go_w[0] = 1'b1;
    @(negedge clk); #1 go_w[0] = 1'b0;
    chk("overrun_set", ovr_w[0], 1'b1);
    repeat (50) @(negedge clk);
    #1 begin go_w[0] = 1'b1; clr = 1'b1; end
    @(negedge clk); #1 begin go_w[0] = 1'b0; clr = 1'b0; end
    chk("overrun_set_wins", ovr_w[0], 1'b1);
    wait_done();
    chk("overrun_sticky", ovr_w[0], 1'b1);
    #1 clr = 1'b1;
    @(negedge clk); #1 clr = 1'b0;
    chk("overrun_cleared", ovr_w[0], 1'b0);

    // reset in the middle of the H word
    issue(0, 11'd2, 11'd0, 1'b0, 390);
    repeat (119) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_csn", csn_w[0], 1'b1);
    chk("abort_sclk", sclk_w[0], 1'b0);
    chk("abort_mosi", mosi_w[0], 1'b0);
    chk("abort_busy", busy_w[0], 1'b0);
    exp_done_q.delete();
    exp_word_q.delete();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // restart from start after reset, then the 12-bit overflow wrap
    set_cfg(11'd100, 11'd2047, 11'd2047, 11'd0, 11'd1, 11'd1);
    issue(0, 11'd100, 11'd0, 1'b0, 390); wait_done();
    issue(0, 11'd100, 11'd1, 1'b0, 390); wait_done();
    issue(0, 11'd100, 11'd0, 1'b1, 390); wait_done();

    // fast instance; v_step=0 counts as a V wrap
    set_cfg(11'd5, 11'd9, 11'd3, 11'd7, 11'd7, 11'd0);
    issue(1, 11'd5, 11'd7, 1'b0, 195); wait_done();
    issue(1, 11'd8, 11'd7, 1'b0, 195); wait_done();
    issue(1, 11'd5, 11'd7, 1'b1, 195); wait_done();

    repeat (5) @(negedge clk);
    chk("leftover_words", exp_word_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
